pool_sched: RTL and testbench

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_sched.sv | 209 ++++++++++++++++++++
 tb/tb_pool_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sched.sv
// rtl/pool_sched.sv - feature-map streaming scheduler feeding a 2x2 pooling unit
//
// Purpose:
//   Streams one LEN x ROWS feature map out of a synchronous read buffer into a
//   pooling unit, inserting GAP idle cycles between rows, collects the pooled
//   results into an output buffer and waits (bounded) for the pooling unit to
//   report completion. Protocol problems raise a sticky err flag.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           begin a pass (sampled only while idle)
//   fm_rd_en/addr   feature-map read strobe and address (row*LEN+col)
//   fm_rd_data      read data, valid the cycle after fm_rd_en
//   pl_load, pl_in  pooling unit enable and registered sample
//   pl_result/valid pooled value and its qualifier
//   pl_done         pooling unit finished the map
//   ob_wr_en/addr/data  output buffer write port
//   busy, done, err pass in progress, one-cycle completion pulse, sticky error

module pool_sched #(
  parameter int LEN       = 8,
  parameter int ROWS      = 8,
  parameter int GAP       = 2,
  parameter int DW        = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          fm_rd_en,
  output logic [5:0]    fm_rd_addr,
  input  logic [DW-1:0] fm_rd_data,
  output logic          pl_load,
  output logic [DW-1:0] pl_in,
  input  logic [DW-1:0] pl_result,
  input  logic          pl_valid,
  input  logic          pl_done,
  output logic          ob_wr_en,
  output logic [3:0]    ob_wr_addr,
  output logic [DW-1:0] ob_wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int NRES = (ROWS / 2) * (LEN / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_GAP,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    gap_q, gap_d;
  logic [15:0]   drain_q, drain_d;
  logic [4:0]    res_q, res_d;
  logic          err_q, err_d;
  logic          pl_load_q, pl_load_d;
  logic          rd_vld_q;
  logic [DW-1:0] pl_in_q;
  logic          wr_fire;

  // Next-state and result-capture logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    res_d   = res_q;
    err_d   = err_q;
    wr_fire = 1'b0;

    // Results are accepted in every active state; anything beyond the
    // expected count is dropped and flagged.
    if (state_q != S_IDLE && pl_valid) begin
      if (res_q < 5'(NRES)) begin
        wr_fire = 1'b1;
        res_d   = res_q + 5'd1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          gap_d   = '0;
          drain_d = '0;
          res_d   = '0;
          err_d   = 1'b0;
        end
      end

      S_STREAM: begin
        // addr_q tracks row*LEN+col incrementally; it is only driven out
        // while streaming, so the wrap after the final sample is harmless.
        addr_d = addr_q + 6'd1;
        if (col_q == 6'(LEN - 1)) begin
          col_d = '0;
          if (row_q == 6'(ROWS - 1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            row_d   = row_q + 6'd1;
            gap_d   = '0;
            state_d = (GAP == 0) ? S_STREAM : S_GAP;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end

      S_GAP: begin
        if (gap_q == 8'(GAP - 1)) begin
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      S_DRAIN: begin
        if (pl_done) begin
          state_d = S_FINISH;
          // res_d already includes a result arriving alongside pl_done.
          if (res_d < 5'(NRES)) begin
            err_d = 1'b1;
          end
        end else if (drain_q == 16'(DRAIN_MAX - 1)) begin
          state_d = S_FINISH;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // pl_load rises together with the first registered sample and is
    // dropped on entry to FINISH.
    pl_load_d = pl_load_q;
    if (state_q == S_IDLE || state_d == S_FINISH) begin
      pl_load_d = 1'b0;
    end else if (rd_vld_q) begin
      pl_load_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      gap_q     <= '0;
      drain_q   <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      pl_load_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      pl_in_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      drain_q   <= drain_d;
      res_q     <= res_d;
      err_q     <= err_d;
      pl_load_q <= pl_load_d;
      // Read data returns one cycle after the strobe; register it then.
      rd_vld_q  <= fm_rd_en;
      if (rd_vld_q) begin
        pl_in_q <= fm_rd_data;
      end
    end
  end

  assign fm_rd_en   = (state_q == S_STREAM);
  assign fm_rd_addr = fm_rd_en ? addr_q : 6'd0;
  assign pl_load    = pl_load_q;
  assign pl_in      = pl_in_q;
  assign ob_wr_en   = wr_fire;
  assign ob_wr_addr = wr_fire ? res_q[3:0] : 4'd0;
  assign ob_wr_data = wr_fire ? pl_result : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign err        = err_q;

endmodule

// File: tb/tb_pool_sched.sv
// tb/tb_pool_sched.sv - directed self-checking bench for pool_sched

module tb_pool_sched;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          fm_rd_en;
  logic [5:0]    fm_rd_addr;
  logic [DW-1:0] fm_rd_data;
  logic          pl_load;
  logic [DW-1:0] pl_in;
  logic [DW-1:0] pl_result;
  logic          pl_valid;
  logic          pl_done;
  logic          ob_wr_en;
  logic [3:0]    ob_wr_addr;
  logic [DW-1:0] ob_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  pool_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fm_rd_en   (fm_rd_en),
    .fm_rd_addr (fm_rd_addr),
    .fm_rd_data (fm_rd_data),
    .pl_load    (pl_load),
    .pl_in      (pl_in),
    .pl_result  (pl_result),
    .pl_valid   (pl_valid),
    .pl_done    (pl_done),
    .ob_wr_en   (ob_wr_en),
    .ob_wr_addr (ob_wr_addr),
    .ob_wr_data (ob_wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Synchronous feature-map buffer.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];
  end

  int errors = 0;
  int checks = 0;

  // Observation logs, sampled on the falling edge.
  int            cyc = 0;
  int            rd_n, wr_n, done_n, pl_in_bad, first_rd_cyc, done_cyc;
  int            rd_cyc [64];
  logic [5:0]    rd_addr_log [64];
  logic [3:0]    wr_addr_log [32];
  logic [DW-1:0] wr_data_log [32];
  logic          lat_load1, lat_load2, done_pl_load;
  logic [DW-1:0] lat_in2;
  logic          p1_en, p2_en;
  logic [5:0]    p1_a, p2_a;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      p1_en <= 1'b0;
      p2_en <= 1'b0;
    end else begin
      p1_en <= fm_rd_en;
      p1_a  <= fm_rd_addr;
      p2_en <= p1_en;
      p2_a  <= p1_a;
      if (p2_en && pl_in !== mem[p2_a]) pl_in_bad <= pl_in_bad + 1;
    end
    if (fm_rd_en) begin
      if (rd_n < 64) begin
        rd_cyc[rd_n]      <= cyc;
        rd_addr_log[rd_n] <= fm_rd_addr;
      end
      if (rd_n == 0) first_rd_cyc <= cyc;
      rd_n <= rd_n + 1;
    end
    if (cyc == first_rd_cyc + 1) lat_load1 <= pl_load;
    if (cyc == first_rd_cyc + 2) begin
      lat_in2   <= pl_in;
      lat_load2 <= pl_load;
    end
    if (ob_wr_en) begin
      if (wr_n < 32) begin
        wr_addr_log[wr_n] <= ob_wr_addr;
        wr_data_log[wr_n] <= ob_wr_data;
      end
      wr_n <= wr_n + 1;
    end
    if (done) begin
      done_n       <= done_n + 1;
      done_cyc     <= cyc;
      done_pl_load <= pl_load;
    end
  end

  task automatic clear_logs();
    rd_n = 0; wr_n = 0; done_n = 0; pl_in_bad = 0; done_cyc = 0;
    first_rd_cyc = -100; lat_load1 = 1'b0; lat_load2 = 1'b0; lat_in2 = '0;
    done_pl_load = 1'b0;
  endtask

  // Counts read-address and read-spacing deviations (8 reads, 2 idle).
  task automatic count_addr_bad(output int bad);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (rd_addr_log[i] != 6'(i)) bad++;
      if (i > 0 && (rd_cyc[i] - rd_cyc[i-1]) != ((i % 8 == 0) ? 3 : 1)) bad++;
    end
  endtask

  // Counts output writes deviating from index k / value 100+k.
  task automatic count_wr_bad(output int bad);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (wr_addr_log[k] != 4'(k)) bad++;
      if (wr_data_log[k] != DW'(100 + k)) bad++;
    end
  endtask

  // One full pass. done_mode: 0 never, 1 with last valid, 2 cycle after.
  task automatic run_pass(input int nvalid, input int done_mode,
                          input bit poke_start, output bit ok);
    bit poked;
    ok = 1'b1;
    poked = 1'b0;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 300 && rd_n < 64; c++) begin
      @(posedge clk); #1;
      if (poke_start && !poked && rd_n >= 10) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (rd_n < 64) ok = 1'b0;
    for (int k = 0; k < nvalid; k++) begin
      pl_valid  = 1'b1;
      pl_result = DW'(100 + k);
      pl_done   = (done_mode == 1 && k == nvalid - 1);
      @(posedge clk); #1;
    end
    pl_valid = 1'b0;
    pl_done  = (done_mode == 2);
    @(posedge clk); #1;
    pl_done = 1'b0;
    for (int c = 0; c < 150 && done_n == 0; c++) begin
      @(negedge clk); #1;
    end
    if (done_n == 0) ok = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({fm_rd_en, fm_rd_addr} !== 7'd0) begin
      errors++; $display("FAIL reset_rd: got en=%0b addr=%0d want 0 0", fm_rd_en, fm_rd_addr);
    end
    checks++;
    if ({pl_load, pl_in} !== 17'd0) begin
      errors++; $display("FAIL reset_pl: got load=%0b in=%0d want 0 0", pl_load, pl_in);
    end
    checks++;
    if ({ob_wr_en, ob_wr_addr, ob_wr_data} !== 21'd0) begin
      errors++; $display("FAIL reset_ob: got en=%0b addr=%0d data=%0d want 0", ob_wr_en, ob_wr_addr, ob_wr_data);
    end
    checks++;
    if ({busy, done, err} !== 3'd0) begin
      errors++; $display("FAIL reset_status: got busy=%0b done=%0b err=%0b want 0", busy, done, err);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok; int bad;
    run_pass(16, 1, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nom_timeout: got ok=0 want 1"); end
    checks++;
    if (lat_load1 !== 1'b0) begin errors++; $display("FAIL lat_load_t1: got %0b want 0", lat_load1); end
    checks++;
    if (lat_in2 !== DW'(38)) begin errors++; $display("FAIL lat_pl_in_t2: got %0d want 38", lat_in2); end
    checks++;
    if (lat_load2 !== 1'b1) begin errors++; $display("FAIL lat_load_t2: got %0b want 1", lat_load2); end
    checks++;
    if (rd_n != 64) begin errors++; $display("FAIL nom_reads: got %0d want 64", rd_n); end
    count_addr_bad(bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nom_addr_pattern: got %0d deviations want 0", bad); end
    checks++;
    if (pl_in_bad != 0) begin errors++; $display("FAIL nom_pl_in: got %0d wrong samples want 0", pl_in_bad); end
    checks++;
    if (wr_n != 16) begin errors++; $display("FAIL nom_writes: got %0d want 16", wr_n); end
    count_wr_bad(bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nom_wr_content: got %0d deviations want 0", bad); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL nom_done_pulse: got %0d cycles want 1", done_n); end
    checks++;
    if (done_pl_load !== 1'b0) begin errors++; $display("FAIL nom_load_at_done: got %0b want 0", done_pl_load); end
    checks++;
    if ({busy, err} !== 2'b00) begin errors++; $display("FAIL nom_end_status: got busy=%0b err=%0b want 0 0", busy, err); end
  endtask

  task automatic test_drain_timeout();
    bit ok;
    run_pass(0, 0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_timeout: got ok=0 want 1"); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b want 1", err); end
    checks++;
    if (done_cyc - rd_cyc[63] != 65) begin
      errors++; $display("FAIL to_drain_len: got %0d want 65", done_cyc - rd_cyc[63]);
    end
    checks++;
    if (done_n != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_end: got done_n=%0d busy=%0b want 1 0", done_n, busy);
    end
  endtask

  task automatic test_start_ignored();
    bit ok; int bad;
    run_pass(16, 1, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL si_timeout: got ok=0 want 1"); end
    count_addr_bad(bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL si_addr_pattern: got %0d deviations want 0", bad); end
    checks++;
    if (wr_n != 16 || done_n != 1) begin
      errors++; $display("FAIL si_counts: got wr=%0d done=%0d want 16 1", wr_n, done_n);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL si_err: got %0b want 0", err); end
  endtask

  task automatic test_reset_midpass();
    bit ok; int bad; int wr_before;
    clear_logs();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 200 && rd_n < 29; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (rd_n != 29 || rd_addr_log[28] != 6'd28) begin
      errors++; $display("FAIL mr_reach: got reads=%0d last=%0d want 29 28", rd_n, rd_addr_log[28]);
    end
    rst = 1'b1;
    pl_valid = 1'b1;
    pl_result = DW'(77);
    #1;
    checks++;
    if ({fm_rd_en, fm_rd_addr, pl_load, pl_in, ob_wr_en, ob_wr_addr, ob_wr_data, busy, done, err} !== '0) begin
      errors++; $display("FAIL mr_outputs: got en=%0b addr=%0d load=%0b in=%0d wr=%0b busy=%0b want all 0",
                         fm_rd_en, fm_rd_addr, pl_load, pl_in, ob_wr_en, busy);
    end
    wr_before = wr_n;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_n != wr_before) begin errors++; $display("FAIL mr_no_write: got %0d writes want %0d", wr_n, wr_before); end
    pl_valid = 1'b0;
    rst = 1'b0;
    run_pass(16, 1, 1'b0, ok);
    count_addr_bad(bad);
    checks++;
    if (!ok || rd_addr_log[0] != 6'd0 || bad != 0) begin
      errors++; $display("FAIL mr_restart: got ok=%0b first=%0d dev=%0d want 1 0 0", ok, rd_addr_log[0], bad);
    end
    checks++;
    if (wr_n != 16 || err !== 1'b0) begin
      errors++; $display("FAIL mr_writes: got wr=%0d err=%0b want 16 0", wr_n, err);
    end
  endtask

  task automatic test_overflow();
    bit ok; int bad;
    run_pass(17, 2, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ov_timeout: got ok=0 want 1"); end
    checks++;
    if (wr_n != 16) begin errors++; $display("FAIL ov_writes: got %0d want 16", wr_n); end
    count_wr_bad(bad);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ov_wr_content: got %0d deviations want 0", bad); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ov_err: got %0b want 1", err); end
  endtask

  initial begin
    logic [DW-1:0] r01 [16];
    rst = 1'b1; start = 1'b0; pl_valid = 1'b0; pl_done = 1'b0; pl_result = '0;
    r01 = '{16'd38, 16'd34, 16'd25, 16'd27, 16'd19, 16'd40, 16'd21, 16'd9,
            16'd45, 16'd12, 16'd10, 16'd6, 16'd30, 16'd31, 16'd15, 16'd44};
    for (int i = 0; i < 64; i++) mem[i] = (i < 16) ? r01[i] : DW'((i * 13) % 97 + 1);
    clear_logs();
    test_reset();
    test_nominal();
    test_drain_timeout();
    test_start_ignored();
    test_reset_midpass();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 time units want finish");
    $fatal(1, "watchdog");
  end

endmodule
